bit_count_launcher: RTL and testbench

Front-end control stage that feeds the bit-counting FSMD. It debounces the start push-button and latches the 4-bit switch value onto `dataA`. It then holds `dataA` stable for a programmable setup window before raising `command`, and runs the full `command`/`done` handshake. When the counter finishes, it captures the count and presents it as a registered result with a valid flag. It runs on the 100 MHz board clock; the counter's `done` and `bitCount` come from its slow-clock domain and are synchronized here.

---
 rtl/bit_count_pkg.sv | 23 ++
 rtl/bit_count_launcher_debounce.sv | 45 ++++
 rtl/bit_count_launcher.sv | 121 ++++++++++++
 tb/tb_bit_count_launcher.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_count_pkg.sv
// Shared definitions for the bit-count launcher: FSM states, data widths and
// default timing parameters for the 100 MHz board clock.
package bit_count_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned COUNT_W = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_SETUP_CYCLES    = 250_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    CMD_HI = 2'd2,
    CMD_LO = 2'd3
  } state_t;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_count_launcher_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a one-cycle press pulse on the accepted rising level.
module btn_debounce
  import bit_count_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], btn};
      stable_q <= stable;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // High during the cycle in which the stable level has just risen.
  assign press = stable & ~stable_q;

endmodule

// File: rtl/bit_count_launcher.sv
// Front end for the bit-counting FSMD: latches the switch operand on a
// debounced press, waits a setup window, then runs the command/done handshake.
module bit_count_launcher
  import bit_count_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic [DATA_W-1:0]  sw_data,
  input  logic               done,
  input  logic [COUNT_W-1:0] bit_count,
  output logic               command,
  output logic [DATA_W-1:0]  dataA,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  output logic               busy
);

  localparam int unsigned SW = cnt_width(SETUP_CYCLES);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

  logic               press;
  logic [1:0]         done_sync;
  logic [COUNT_W-1:0] bc_s1;
  logic [COUNT_W-1:0] bc_s2;

  state_t             state;
  state_t             state_n;
  logic [SW-1:0]      setup_cnt;
  logic [SW-1:0]      setup_cnt_n;
  logic               command_n;
  logic [DATA_W-1:0]  dataA_n;
  logic [COUNT_W-1:0] result_n;
  logic               result_valid_n;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_start),
    .press(press)
  );

  // bit_count is held constant while done is high, so a plain bus
  // synchronizer is safe: it has settled by the time synced done rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_sync <= '0;
      bc_s1     <= '0;
      bc_s2     <= '0;
    end else begin
      done_sync <= {done_sync[0], done};
      bc_s1     <= bit_count;
      bc_s2     <= bc_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      setup_cnt    <= '0;
      command      <= 1'b0;
      dataA        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      setup_cnt    <= setup_cnt_n;
      command      <= command_n;
      dataA        <= dataA_n;
      result       <= result_n;
      result_valid <= result_valid_n;
    end
  end

  always_comb begin
    state_n        = state;
    setup_cnt_n    = setup_cnt;
    command_n      = command;
    dataA_n        = dataA;
    result_n       = result;
    result_valid_n = result_valid;
    case (state)
      IDLE: begin
        if (press) begin
          dataA_n        = sw_data;
          result_valid_n = 1'b0;
          setup_cnt_n    = '0;
          state_n        = SETUP;
        end
      end
      SETUP: begin
        setup_cnt_n = setup_cnt + 1'b1;
        if (setup_cnt == SETUP_LAST) begin
          command_n = 1'b1;
          state_n   = CMD_HI;
        end
      end
      CMD_HI: begin
        if (done_sync[1]) begin
          result_n  = bc_s2;
          command_n = 1'b0;
          state_n   = CMD_LO;
        end
      end
      CMD_LO: begin
        if (!done_sync[1]) begin
          result_valid_n = 1'b1;
          state_n        = IDLE;
        end
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bit_count_launcher.sv
// Directed/randomized bench for bit_count_launcher with an inline model of the
// downstream bit counter; expected counts come from the operands driven.
module tb_bit_count_launcher;

  localparam int unsigned DEB = 4;
  localparam int unsigned SET = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic [3:0] sw_data;
  logic       done;
  logic [2:0] bit_count;
  logic       command;
  logic [3:0] dataA;
  logic [2:0] result;
  logic       result_valid;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [2:0]  last_result;
  logic [3:0]  op;

  bit_count_launcher #(
    .DEBOUNCE_CYCLES(DEB),
    .SETUP_CYCLES   (SET)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .sw_data     (sw_data),
    .done        (done),
    .bit_count   (bit_count),
    .command     (command),
    .dataA       (dataA),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ones(input logic [3:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 4; i++) c += v[i];
    return 3'(c);
  endfunction

  // Release the button long enough to re-arm, then press cleanly with operand v.
  task automatic press(input logic [3:0] v);
    int unsigned waited;
    btn_start = 1'b0;
    repeat (DEB + 4) tick();
    sw_data   = v;
    btn_start = 1'b1;
    waited    = 0;
    while (busy !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check("press_seen", busy, 1);
    check("press_latency", waited, DEB + 3);
    check("dataA_latch", dataA, v);
    check("valid_cleared", result_valid, 0);
    check("result_held", result, last_result);
    sw_data = ~v;
    tick(); check("cmd_early1", command, 0);
    tick(); check("cmd_early2", command, 0);
    check("dataA_hold", dataA, v);
    tick(); check("cmd_rise", command, 1);
  endtask

  // Counter model: after `delay` cycles report the ones-count, then finish.
  task automatic handshake(input logic [3:0] v, input int unsigned delay);
    logic [2:0] exp;
    exp = ones(v);
    repeat (delay) tick();
    bit_count = ones(dataA);
    done      = 1'b1;
    tick(); tick();
    check("cmd_hold_sync", command, 1);
    tick();
    check("cmd_fall", command, 0);
    check("result_cap", result, exp);
    check("valid_low_cmdlo", result_valid, 0);
    check("busy_cmdlo", busy, 1);
    repeat (4) tick();
    done = 1'b0;
    tick(); tick();
    check("valid_sync", result_valid, 0);
    tick();
    check("valid_rise", result_valid, 1);
    check("busy_idle", busy, 0);
    check("result_final", result, exp);
    bit_count   = 3'($urandom);
    last_result = exp;
  endtask

  initial begin
    reset       = 1'b0;
    btn_start   = 1'b0;
    done        = 1'b0;
    sw_data     = 4'h0;
    bit_count   = 3'd0;
    last_result = 3'd0;
    repeat (3) tick();
    check("rst_command", command, 0);
    check("rst_dataA", dataA, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Bounce: 2-cycle toggles never satisfy the debounce window.
    for (int i = 0; i < 20; i++) begin
      btn_start = ((i / 2) % 2) == 0;
      sw_data   = 4'($urandom);
      tick();
      check("bounce_idle", busy, 0);
    end
    press(4'b1011);

    // Lockout: a second press and switch change while waiting for done.
    btn_start = 1'b0;
    repeat (8) tick();
    sw_data   = 4'b0001;
    btn_start = 1'b1;
    repeat (8) tick();
    check("lock_dataA", dataA, 4'b1011);
    check("lock_command", command, 1);
    check("lock_busy", busy, 1);
    handshake(4'b1011, 1);
    repeat (10) tick();
    check("single_busy", busy, 0);
    check("single_result", result, 3);
    check("single_valid", result_valid, 1);

    for (int k = 0; k < 4; k++) begin
      op = 4'($urandom_range(0, 15));
      press(op);
      handshake(op, $urandom_range(1, 20));
    end

    // Reset while in CMD_HI; the counter's late done must be ignored.
    op = 4'($urandom_range(0, 15));
    press(op);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_command", command, 0);
    check("midrst_dataA", dataA, 0);
    check("midrst_result", result, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_busy", busy, 0);
    btn_start = 1'b0;
    tick(); tick();
    reset       = 1'b1;
    last_result = 3'd0;
    bit_count   = 3'($urandom);
    done        = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) done = 1'b0;
      tick();
      check("ignore_done_busy", busy, 0);
      check("ignore_done_cmd", command, 0);
      check("ignore_done_valid", result_valid, 0);
    end
    press(4'b1111);
    handshake(4'b1111, 10);

    press(4'b0000);
    handshake(4'b0000, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
